// File: rtl/bn_pkg.sv
// Shared constants, legality check and FSM encoding for the batch-norm parameter path.
package bn_pkg;

  localparam logic [3:0] BN_FACTOR_IDENTITY = 4'b0100;
  localparam logic [3:0] BN_FACTOR_X8       = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } bn_state_e;

  // Codes 0000, 0111, 1011, 1111 have no defined scaling in the BN datapath.
  function automatic logic bn_factor_is_legal(input logic [3:0] factor);
    case (factor)
      4'b0000, 4'b0111, 4'b1011, 4'b1111: bn_factor_is_legal = 1'b0;
      default:                            bn_factor_is_legal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/bn_param_sanitize.sv
// Combinational cleanup of one raw (factor, addend) record; flags any substitution.
module bn_param_sanitize
  import bn_pkg::*;
#(
  parameter int ADDEND_WIDTH = 4
) (
  input  logic [3:0]              factor_raw,
  input  logic [ADDEND_WIDTH-1:0] addend_raw,
  output logic [3:0]              factor_clean,
  output logic [ADDEND_WIDTH-1:0] addend_clean,
  output logic                    illegal
);

  always_comb begin
    factor_clean = factor_raw;
    addend_clean = addend_raw;
    illegal      = 1'b0;
    if (!bn_factor_is_legal(factor_raw)) begin
      factor_clean = BN_FACTOR_IDENTITY;
      addend_clean = '0;
      illegal      = 1'b1;
    end else if (factor_raw == BN_FACTOR_X8 && addend_raw != '0) begin
      // x8 scaling leaves no headroom for an offset
      addend_clean = '0;
      illegal      = 1'b1;
    end
  end

endmodule

// File: rtl/bn_param_loader.sv
// Byte-serial loader for per-neuron BN parameters with shadow/active double buffering.
//   state     | meaning
//   ST_IDLE   | waiting for start, data_ready low
//   ST_LOAD   | accepting records into shadow bank
//   ST_COMMIT | copying shadow to active, done pulses next cycle
module bn_param_loader
  import bn_pkg::*;
#(
  parameter int NEURONS      = 4,
  parameter int ADDEND_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [7:0]                      data_in,
  input  logic                            data_valid,
  output logic                            data_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [4*NEURONS-1:0]            bn_factor_all,
  output logic [ADDEND_WIDTH*NEURONS-1:0] bn_addend_all
);

  localparam int PTR_W = $clog2(NEURONS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NEURONS - 1);

  bn_state_e state, state_next;
  logic [PTR_W-1:0] ptr;

  logic [3:0]              shadow_factor [NEURONS];
  logic [ADDEND_WIDTH-1:0] shadow_addend [NEURONS];
  logic [3:0]              active_factor [NEURONS];
  logic [ADDEND_WIDTH-1:0] active_addend [NEURONS];

  logic [3:0]              clean_factor;
  logic [ADDEND_WIDTH-1:0] clean_addend;
  logic                    clean_illegal;
  logic                    accept;

  bn_param_sanitize #(.ADDEND_WIDTH(ADDEND_WIDTH)) u_sanitize (
    .factor_raw   (data_in[7:4]),
    .addend_raw   (data_in[ADDEND_WIDTH-1:0]),
    .factor_clean (clean_factor),
    .addend_clean (clean_addend),
    .illegal      (clean_illegal)
  );

  assign data_ready = (state == ST_LOAD);
  assign busy       = (state != ST_IDLE);
  // A restart wins over a byte offered in the same cycle.
  assign accept     = data_valid && data_ready && !start;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_LOAD;
      ST_LOAD:   if (accept && ptr == PTR_LAST) state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
      done  <= 1'b0;
      error <= 1'b0;
      for (int i = 0; i < NEURONS; i++) begin
        shadow_factor[i] <= BN_FACTOR_IDENTITY;
        shadow_addend[i] <= '0;
        active_factor[i] <= BN_FACTOR_IDENTITY;
        active_addend[i] <= '0;
      end
    end else begin
      state <= state_next;
      done  <= (state == ST_COMMIT);
      case (state)
        ST_IDLE: begin
          if (start) begin
            ptr   <= '0;
            error <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (start) begin
            ptr   <= '0;
            error <= 1'b0;
          end else if (accept) begin
            shadow_factor[ptr] <= clean_factor;
            shadow_addend[ptr] <= clean_addend;
            error              <= error | clean_illegal;
            ptr                <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < NEURONS; i++) begin
            active_factor[i] <= shadow_factor[i];
            active_addend[i] <= shadow_addend[i];
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NEURONS; g++) begin : g_flat
    assign bn_factor_all[4*g +: 4]                       = active_factor[g];
    assign bn_addend_all[ADDEND_WIDTH*g +: ADDEND_WIDTH] = active_addend[g];
  end

endmodule
